// File: rtl/dec_entry_pkg.sv
// Shared types, constants and helpers for the three-digit BCD entry block.
package dec_entry_pkg;

    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned DIG_W      = 4;
    localparam int unsigned VAL_W      = 10;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // d2 is the oldest entered digit, d0 the most recent
    typedef struct packed {
        logic [DIG_W-1:0] d2;
        logic [DIG_W-1:0] d1;
        logic [DIG_W-1:0] d0;
    } digits_t;

    function automatic logic [SEG_W-1:0] seg7(input logic [DIG_W-1:0] bcd);
        case (bcd)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One Horner step; operands never exceed 99*10+9, so 10 bits suffice
    function automatic logic [VAL_W-1:0] mac10(input logic [VAL_W-1:0] acc,
                                               input logic [DIG_W-1:0] dig);
        return VAL_W'(acc * 10'd10) + VAL_W'(dig);
    endfunction

endpackage

// File: rtl/dec_entry_key_pulse.sv
// key_pulse: 2-flop synchronizer plus one-shot press detector for an active-low key.
// Optional debounce filter enabled by DEC_ENTRY_DEBOUNCE_EN.
module key_pulse
`ifdef DEC_ENTRY_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic s1, s2;
    logic v1, v2;
    logic ready;

`ifdef DEC_ENTRY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] low_cnt;
`endif

    // v1/v2 mark when s2 holds a real sample; ready requires a real release before a press counts
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            v1    <= 1'b0;
            v2    <= 1'b0;
            ready <= 1'b0;
            pulse <= 1'b0;
`ifdef DEC_ENTRY_DEBOUNCE_EN
            low_cnt <= '0;
`endif
        end else begin
            s1    <= key;
            s2    <= s1;
            v1    <= 1'b1;
            v2    <= v1;
            pulse <= 1'b0;
            if (v2 && s2) begin
                ready <= 1'b1;
            end
`ifdef DEC_ENTRY_DEBOUNCE_EN
            if (v2 && !s2 && ready) begin
                if (low_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    pulse   <= 1'b1;
                    ready   <= 1'b0;
                    low_cnt <= '0;
                end else begin
                    low_cnt <= low_cnt + 1'b1;
                end
            end else begin
                low_cnt <= '0;
            end
`else
            if (v2 && !s2 && ready) begin
                pulse <= 1'b1;
                ready <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/dec_entry.sv
// dec_entry: three-digit BCD keypad entry, converted to binary on commit.
// Define DEC_ENTRY_DEBOUNCE_EN to debounce the keys (adds DEBOUNCE_CYCLES parameter).
module dec_entry
    import dec_entry_pkg::*;
`ifdef DEC_ENTRY_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic                 CLOCK_50,
    input  logic                 RST,
    input  logic [DIG_W-1:0]     SW,
    input  logic [2:0]           KEY,
    output logic [VAL_W-1:0]     LEDR,
    output logic                 DONE,
    output logic                 ERR,
    output logic [SEG_W-1:0]     HEX0,
    output logic [SEG_W-1:0]     HEX1,
    output logic [SEG_W-1:0]     HEX2,
    output logic [SEG_W-1:0]     HEX3
);

    logic [2:0]        pulse;
    logic              enter, commit, clear;
    state_t            state;
    digits_t           dig;
    logic [1:0]        count;
    logic [1:0]        step;
    logic [VAL_W-1:0]  acc;
    logic [DIG_W-1:0]  conv_digit;

    for (genvar i = 0; i < 3; i++) begin : g_key
`ifdef DEC_ENTRY_DEBOUNCE_EN
        key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pulse (
`else
        key_pulse u_key_pulse (
`endif
            .clk   (CLOCK_50),
            .rst   (RST),
            .key   (KEY[i]),
            .pulse (pulse[i])
        );
    end

    assign enter  = pulse[0];
    assign commit = pulse[1];
    assign clear  = pulse[2];

    always_comb begin
        conv_digit = dig.d0;
        case (step)
            2'd0:    conv_digit = dig.d2;
            2'd1:    conv_digit = dig.d1;
            default: conv_digit = dig.d0;
        endcase
    end

    // Entry/convert FSM; if-else order gives clear > commit > enter
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state <= ST_IDLE;
            dig   <= '0;
            count <= '0;
            step  <= '0;
            acc   <= '0;
            LEDR  <= '0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (clear) begin
                        dig   <= '0;
                        count <= '0;
                        ERR   <= 1'b0;
                        state <= ST_IDLE;
                    end else if (commit) begin
                        if (count == 2'd0) begin
                            ERR <= 1'b1;
                        end else begin
                            acc   <= '0;
                            step  <= '0;
                            state <= ST_CONVERT;
                        end
                    end else if (enter) begin
                        if (SW > 4'd9 || count == 2'(MAX_DIGITS)) begin
                            ERR <= 1'b1;
                        end else begin
                            dig   <= '{d2: dig.d1, d1: dig.d0, d0: SW};
                            count <= count + 2'd1;
                            ERR   <= 1'b0;
                            state <= ST_ENTRY;
                        end
                    end
                end
                ST_CONVERT: begin
                    acc <= mac10(acc, conv_digit);
                    if (step == 2'd2) begin
                        LEDR  <= mac10(acc, conv_digit);
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                ST_DONE: begin
                    dig   <= '0;
                    count <= '0;
                    step  <= '0;
                    ERR   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Display: digit positions at or above count stay blank
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
        end else begin
            HEX0 <= (count > 2'd0) ? seg7(dig.d0) : SEG_BLANK;
            HEX1 <= (count > 2'd1) ? seg7(dig.d1) : SEG_BLANK;
            HEX2 <= (count > 2'd2) ? seg7(dig.d2) : SEG_BLANK;
            HEX3 <= ERR ? SEG_DASH : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_dec_entry.sv
// Self-checking bench for dec_entry: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_dec_entry;

    logic       CLOCK_50 = 1'b0;
    logic       RST;
    logic [3:0] SW;
    logic [2:0] KEY;
    logic [9:0] LEDR;
    logic       DONE, ERR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    always #10 CLOCK_50 = ~CLOCK_50;

    dec_entry dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .DONE     (DONE),
        .ERR      (ERR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                           G9 = 7'b0010000;
    logic [6:0] segtab [10];

    localparam logic [2:0] EN = 3'b001, CM = 3'b010, CL = 3'b100;

    typedef struct {
        logic [2:0] mask;
        logic [3:0] sw;
        int         ledr;
        int         err;
        int         done;
        logic [6:0] h3, h2, h1, h0;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // transaction-level model: entered digits oldest first
    int mq[$];
    int m_ledr;
    int m_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] mask, input logic [3:0] sw, input int ledr,
                                input int err, input int done, input logic [6:0] h3,
                                input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        vec_t v;
        v.mask = mask; v.sw = sw; v.ledr = ledr; v.err = err; v.done = done;
        v.h3 = h3; v.h2 = h2; v.h1 = h1; v.h0 = h0;
        return v;
    endfunction

    // Press keys for two cycles; return DONE count and the first cycle it was seen
    task automatic do_press(input logic [2:0] mask, input logic [3:0] sw,
                            output int nd, output int at);
        nd = 0;
        at = 0;
        @(negedge CLOCK_50);
        SW  = sw;
        KEY = ~mask;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (DONE) begin
                nd++;
                if (at == 0) at = k;
            end
            if (k == 2) KEY = 3'b111;
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RST = 1'b1;
        KEY = 3'b111;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RST = 1'b0;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic chk_outs(input string tag, input int ledr, input int err,
                            input logic [6:0] h3, input logic [6:0] h2,
                            input logic [6:0] h1, input logic [6:0] h0);
        chk({tag, " LEDR"}, int'(LEDR), ledr);
        chk({tag, " ERR"},  int'(ERR),  err);
        chk({tag, " HEX3"}, int'(HEX3), int'(h3));
        chk({tag, " HEX2"}, int'(HEX2), int'(h2));
        chk({tag, " HEX1"}, int'(HEX1), int'(h1));
        chk({tag, " HEX0"}, int'(HEX0), int'(h0));
    endtask

    function automatic logic [6:0] mhex(input int pos);
        int n = mq.size();
        if (pos >= n) return BL;
        return segtab[mq[n - 1 - pos]];
    endfunction

    function automatic int model_press(input logic [2:0] mask, input int sw);
        int val;
        if (mask[2]) begin
            mq.delete();
            m_err = 0;
        end else if (mask[1]) begin
            if (mq.size() == 0) begin
                m_err = 1;
            end else begin
                val = 0;
                foreach (mq[i]) val = val * 10 + mq[i];
                m_ledr = val;
                mq.delete();
                m_err = 0;
                return 1;
            end
        end else if (mask[0]) begin
            if (sw > 9 || mq.size() == 3) m_err = 1;
            else begin
                mq.push_back(sw);
                m_err = 0;
            end
        end
        return 0;
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd, at, ed;
        logic [2:0] mask;
        logic [3:0] sw;
        string tag;

        segtab = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};
        RST = 1'b1;
        KEY = 3'b111;
        SW  = 4'd0;

        // Reset values while RST is held
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset DONE", int'(DONE), 0);
        chk_outs("reset", 0, 0, BL, BL, BL, BL);
        RST = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        vt.push_back(mk(EN, 4'd4,    0, 0, 0, BL, BL, BL, G4));
        vt.push_back(mk(EN, 4'd0,    0, 0, 0, BL, BL, G4, G0));
        vt.push_back(mk(EN, 4'd7,    0, 0, 0, BL, G4, G0, G7));
        vt.push_back(mk(CM, 4'd0,  407, 0, 1, BL, BL, BL, BL));
        vt.push_back(mk(EN, 4'd9,  407, 0, 0, BL, BL, BL, G9));
        vt.push_back(mk(CM, 4'd0,    9, 0, 1, BL, BL, BL, BL));
        vt.push_back(mk(EN, 4'd1,    9, 0, 0, BL, BL, BL, G1));
        vt.push_back(mk(EN, 4'd2,    9, 0, 0, BL, BL, G1, G2));
        vt.push_back(mk(EN, 4'd3,    9, 0, 0, BL, G1, G2, G3));
        vt.push_back(mk(EN, 4'd5,    9, 1, 0, DS, G1, G2, G3));
        vt.push_back(mk(CL, 4'd0,    9, 0, 0, BL, BL, BL, BL));
        vt.push_back(mk(EN, 4'd12,   9, 1, 0, DS, BL, BL, BL));
        vt.push_back(mk(CM, 4'd0,    9, 1, 0, DS, BL, BL, BL));
        vt.push_back(mk(EN, 4'd5,    9, 0, 0, BL, BL, BL, G5));
        vt.push_back(mk(EN, 4'd5,    9, 0, 0, BL, BL, G5, G5));
        vt.push_back(mk(CL | CM, 4'd0, 9, 0, 0, BL, BL, BL, BL));
        vt.push_back(mk(CM | EN, 4'd8, 9, 1, 0, DS, BL, BL, BL));
        vt.push_back(mk(EN, 4'd9,    9, 0, 0, BL, BL, BL, G9));
        vt.push_back(mk(EN, 4'd9,    9, 0, 0, BL, BL, G9, G9));
        vt.push_back(mk(EN, 4'd9,    9, 0, 0, BL, G9, G9, G9));
        vt.push_back(mk(CM, 4'd0,  999, 0, 1, BL, BL, BL, BL));
        vt.push_back(mk(EN, 4'd2,  999, 0, 0, BL, BL, BL, G2));
        vt.push_back(mk(CL | EN, 4'd3, 999, 0, 0, BL, BL, BL, BL));

        foreach (vt[i]) begin
            tag = $sformatf("vec%0d", i);
            do_press(vt[i].mask, vt[i].sw, nd, at);
            chk({tag, " DONE count"}, nd, vt[i].done);
            if (vt[i].done != 0) chk({tag, " DONE latency"}, at, 7);
            chk_outs(tag, vt[i].ledr, vt[i].err, vt[i].h3, vt[i].h2, vt[i].h1, vt[i].h0);
        end

        // Keys pressed while converting are dropped
        do_press(EN, 4'd1, nd, at);
        do_press(EN, 4'd2, nd, at);
        nd = 0;
        at = 0;
        @(negedge CLOCK_50);
        SW  = 4'd3;
        KEY = 3'b101;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (DONE) begin
                nd++;
                if (at == 0) at = k;
            end
            if (k == 2) KEY = 3'b010;
            if (k == 4) KEY = 3'b111;
        end
        chk("busy DONE count", nd, 1);
        chk("busy DONE latency", at, 7);
        chk_outs("busy", 12, 0, BL, BL, BL, BL);

        // Randomized run against the model
        do_reset();
        mq.delete();
        m_ledr = 0;
        m_err  = 0;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: mask = EN;
                6, 7:             mask = CM;
                8:                mask = CL;
                default:          mask = 3'($urandom_range(3, 7));
            endcase
            sw = 4'($urandom_range(0, 11));
            ed = model_press(mask, int'(sw));
            do_press(mask, sw, nd, at);
            tag = $sformatf("rnd%0d m%0d s%0d", i, mask, sw);
            chk({tag, " DONE count"}, nd, ed);
            if (ed != 0) chk({tag, " DONE latency"}, at, 7);
            chk_outs(tag, m_ledr, m_err, m_err != 0 ? DS : BL, mhex(2), mhex(1), mhex(0));
        end

        // Reset in the middle of a conversion aborts it
        do_reset();
        do_press(EN, 4'd3, nd, at);
        do_press(CM, 4'd0, nd, at);
        chk("pre-abort LEDR", int'(LEDR), 3);
        do_press(EN, 4'd6, nd, at);
        nd = 0;
        @(negedge CLOCK_50);
        KEY = 3'b101;
        repeat (2) @(negedge CLOCK_50);
        KEY = 3'b111;
        repeat (2) @(negedge CLOCK_50);
        RST = 1'b1;
        @(negedge CLOCK_50);
        chk("abort DONE", int'(DONE), 0);
        chk_outs("abort", 0, 0, BL, BL, BL, BL);
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            if (DONE) nd++;
        end
        chk("abort no DONE", nd, 0);
        chk("abort LEDR after", int'(LEDR), 0);

        // A key held through reset release must not register
        @(negedge CLOCK_50);
        RST = 1'b1;
        SW  = 4'd3;
        KEY = 3'b110;
        repeat (2) @(negedge CLOCK_50);
        RST = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        chk("held HEX0", int'(HEX0), int'(BL));
        chk("held ERR", int'(ERR), 0);
        KEY = 3'b111;
        repeat (4) @(negedge CLOCK_50);
        do_press(EN, 4'd3, nd, at);
        chk("repress HEX0", int'(HEX0), int'(G3));
        chk("repress HEX1", int'(HEX1), int'(BL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
